// File: rtl/tx_ppe_ingr_buf_if.sv
// tx_ppe_ingr_buf_if: egress credit segment bus (egr_seg_*, tx_credit_rtn) and tx_ppe valid/ready bus (ppe_seg_*); slave = buffer side, master = environment side
interface tx_ppe_ingr_buf_if #(
  parameter int DATA_W = 512,
  parameter int MD_W   = 64,
  parameter int BYTE_W = 6
);
  logic              egr_seg_valid;
  logic              egr_seg_sop;
  logic              egr_seg_eop;
  logic [BYTE_W-1:0] egr_seg_bytes;
  logic [MD_W-1:0]   egr_seg_md;
  logic [DATA_W-1:0] egr_seg_data;
  logic [1:0]        tx_credit_rtn;
  logic              ppe_seg_valid;
  logic              ppe_seg_ready;
  logic              ppe_seg_sop;
  logic              ppe_seg_eop;
  logic              ppe_seg_abort;
  logic [BYTE_W-1:0] ppe_seg_bytes;
  logic [MD_W-1:0]   ppe_seg_md;
  logic [DATA_W-1:0] ppe_seg_data;
  modport slave (
    input  egr_seg_valid, egr_seg_sop, egr_seg_eop, egr_seg_bytes, egr_seg_md, egr_seg_data, ppe_seg_ready,
    output tx_credit_rtn, ppe_seg_valid, ppe_seg_sop, ppe_seg_eop, ppe_seg_abort, ppe_seg_bytes, ppe_seg_md, ppe_seg_data
  );
  modport master (
    output egr_seg_valid, egr_seg_sop, egr_seg_eop, egr_seg_bytes, egr_seg_md, egr_seg_data, ppe_seg_ready,
    input  tx_credit_rtn, ppe_seg_valid, ppe_seg_sop, ppe_seg_eop, ppe_seg_abort, ppe_seg_bytes, ppe_seg_md, ppe_seg_data
  );
endinterface

// File: rtl/tx_ppe_ingr_buf.sv
// tx_ppe_ingr_buf: framing-checked segment FIFO with credit return and stats; ports cclk/reset, s (segment buses), stat_clr, stat_pkt_cnt/stat_drop_cnt/stat_ovf
module tx_ppe_ingr_buf #(
  parameter int DATA_W = 512,
  parameter int MD_W   = 64,
  parameter int DEPTH  = 8,
  parameter int BYTE_W = $clog2(DATA_W/8)
) (
  input  logic                cclk,
  input  logic                reset,
  tx_ppe_ingr_buf_if.slave    s,
  input  logic                stat_clr,
  output logic [31:0]         stat_pkt_cnt,
  output logic [15:0]         stat_drop_cnt,
  output logic                stat_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic              abort;
    logic [BYTE_W-1:0] bytes;
    logic [MD_W-1:0]   md;
    logic [DATA_W-1:0] data;
  } entry_t;
  typedef enum logic {IDLE, IN_PKT} state_t;
  entry_t        mem_q [DEPTH];
  entry_t        head;
  state_t        st_q, st_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rtn_q, rtn_d;
  logic [31:0]   pkt_q, pkt_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, wr_req, frm_drop, push, ovf_ev;
  always_comb begin
    head     = mem_q[rd_q];
    full     = cnt_q == CW'(DEPTH);
    empty    = cnt_q == '0;
    pop      = !empty && s.ppe_seg_ready;
    wr_req   = s.egr_seg_valid && (s.egr_seg_sop || st_q == IN_PKT);
    frm_drop = s.egr_seg_valid && !wr_req;
    push     = wr_req && (!full || pop);
    // an overflowed segment is lost but the FSM advances as if it was written
    ovf_ev   = wr_req && !push;
    st_d     = wr_req ? (s.egr_seg_eop ? IDLE : IN_PKT) : st_q;
    wr_d     = push ? ((wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d     = pop ? ((rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    rtn_d    = 2'(pop) + 2'(frm_drop);
    pkt_d    = stat_clr ? '0 : pkt_q + 32'(pop && head.eop);
    drop_d   = stat_clr ? '0 : drop_q + 16'(frm_drop && drop_q != 16'hFFFF);
    ovf_d    = !stat_clr && (ovf_q || ovf_ev);
  end
  always_ff @(posedge cclk) begin
    if (reset) begin
      st_q   <= IDLE;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      rtn_q  <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      rtn_q  <= rtn_d;
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end
  always_ff @(posedge cclk) begin
    if (push) mem_q[wr_q] <= '{sop: s.egr_seg_sop, eop: s.egr_seg_eop, abort: s.egr_seg_sop && st_q == IN_PKT,
                               bytes: s.egr_seg_bytes, md: s.egr_seg_md, data: s.egr_seg_data};
  end
  // head fields are masked so every output reads 0 while the FIFO is empty
  assign s.ppe_seg_valid = !empty;
  assign s.ppe_seg_sop   = !empty && head.sop;
  assign s.ppe_seg_eop   = !empty && head.eop;
  assign s.ppe_seg_abort = !empty && head.abort;
  assign s.ppe_seg_bytes = empty ? '0 : head.bytes;
  assign s.ppe_seg_md    = empty ? '0 : head.md;
  assign s.ppe_seg_data  = empty ? '0 : head.data;
  assign s.tx_credit_rtn = rtn_q;
  assign stat_pkt_cnt    = pkt_q;
  assign stat_drop_cnt   = drop_q;
  assign stat_ovf        = ovf_q;
endmodule

// File: tb/tb_tx_ppe_ingr_buf.sv
// tb_tx_ppe_ingr_buf: scoreboard bench for tx_ppe_ingr_buf
module tb_tx_ppe_ingr_buf;
  typedef struct {
    logic         sop;
    logic         eop;
    logic         abort;
    logic [5:0]   bytes;
    logic [63:0]  md;
    logic [511:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stat_clr = 1'b0;
  logic [31:0] stat_pkt_cnt;
  logic [15:0] stat_drop_cnt;
  logic stat_ovf;
  int checks = 0;
  int errors = 0;
  int rtn_total = 0;
  exp_t sb[$];
  exp_t e;
  tx_ppe_ingr_buf_if #(.DATA_W(512), .MD_W(64), .BYTE_W(6)) bus ();
  tx_ppe_ingr_buf #(.DATA_W(512), .MD_W(64), .DEPTH(8), .BYTE_W(6)) dut (
    .cclk(clk), .reset(reset), .s(bus), .stat_clr(stat_clr),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_ovf(stat_ovf)
  );
  always #5 clk = ~clk;
  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  always @(negedge clk) begin
    if (!reset) begin
      rtn_total += int'(bus.tx_credit_rtn);
      if (bus.ppe_seg_valid && bus.ppe_seg_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got data %0h with empty scoreboard", bus.ppe_seg_data[31:0]);
        end else begin
          e = sb.pop_front();
          if (bus.ppe_seg_sop !== e.sop || bus.ppe_seg_eop !== e.eop || bus.ppe_seg_abort !== e.abort ||
              bus.ppe_seg_bytes !== e.bytes || bus.ppe_seg_data !== e.data || (e.sop && bus.ppe_seg_md !== e.md)) begin
            errors++;
            $display("FAIL out_entry got sop=%b eop=%b abort=%b bytes=%0d md=%0h d=%0h exp sop=%b eop=%b abort=%b bytes=%0d md=%0h d=%0h",
                     bus.ppe_seg_sop, bus.ppe_seg_eop, bus.ppe_seg_abort, bus.ppe_seg_bytes, bus.ppe_seg_md, bus.ppe_seg_data[31:0],
                     e.sop, e.eop, e.abort, e.bytes, e.md, e.data[31:0]);
          end
        end
      end
    end
  end
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.egr_seg_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic send(input logic sop, input logic eop, input logic [5:0] bytes, input logic acc, input logic abort);
    exp_t x;
    x.sop = sop; x.eop = eop; x.abort = abort; x.bytes = bytes;
    x.md = {$urandom, $urandom};
    x.data = rnd512();
    bus.egr_seg_valid = 1'b1;
    bus.egr_seg_sop   = sop;
    bus.egr_seg_eop   = eop;
    bus.egr_seg_bytes = bytes;
    bus.egr_seg_md    = x.md;
    bus.egr_seg_data  = x.data;
    if (acc) sb.push_back(x);
    step();
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left exp 0", sb.size());
    end
  endtask
  task automatic test_reset();
    bus.egr_seg_valid = 0; bus.egr_seg_sop = 0; bus.egr_seg_eop = 0; bus.egr_seg_bytes = 0;
    bus.egr_seg_md = 0; bus.egr_seg_data = 0; bus.ppe_seg_ready = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.ppe_seg_valid !== 1'b0 || bus.tx_credit_rtn !== 2'd0 || stat_pkt_cnt !== 0 || stat_drop_cnt !== 0 || stat_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got valid=%b rtn=%0d pkt=%0d drop=%0d ovf=%b exp all 0",
               bus.ppe_seg_valid, bus.tx_credit_rtn, stat_pkt_cnt, stat_drop_cnt, stat_ovf);
    end
  endtask
  task automatic test_pkt();
    int r0;
    exp_t x;
    r0 = rtn_total;
    bus.ppe_seg_ready = 1'b1;
    x.sop = 1; x.eop = 0; x.abort = 0; x.bytes = 0; x.md = 64'hDEAD_BEEF_0123_4567; x.data = rnd512();
    bus.egr_seg_valid = 1; bus.egr_seg_sop = 1; bus.egr_seg_eop = 0; bus.egr_seg_bytes = 0;
    bus.egr_seg_md = x.md; bus.egr_seg_data = x.data;
    sb.push_back(x);
    #1;
    checks++;
    if (bus.ppe_seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass got valid=%b exp 0", bus.ppe_seg_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ppe_seg_valid !== 1'b1 || bus.ppe_seg_sop !== 1'b1 || bus.ppe_seg_data !== x.data) begin
      errors++;
      $display("FAIL first_latency got valid=%b sop=%b exp valid=1 sop=1", bus.ppe_seg_valid, bus.ppe_seg_sop);
    end
    send(0, 0, 0, 1, 0);
    send(0, 1, 6'd5, 1, 0);
    idle(1);
    wait_drain();
    idle(3);
    checks++;
    if (stat_pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL pkt_cnt_1 got %0d exp 1", stat_pkt_cnt);
    end
    checks++;
    if (rtn_total - r0 != 3) begin
      errors++;
      $display("FAIL credits_pkt got %0d exp 3", rtn_total - r0);
    end
  endtask
  task automatic test_overflow();
    int r0;
    logic [511:0] h;
    r0 = rtn_total;
    bus.ppe_seg_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1, 1, 6'(i), 1, 0);
    idle(1);
    h = bus.ppe_seg_data;
    idle(3);
    checks++;
    if (bus.ppe_seg_valid !== 1'b1 || bus.ppe_seg_data !== h || h !== sb[0].data) begin
      errors++;
      $display("FAIL head_stable got valid=%b d=%0h exp valid=1 d=%0h", bus.ppe_seg_valid, bus.ppe_seg_data[31:0], sb[0].data[31:0]);
    end
    checks++;
    if (rtn_total != r0 || stat_ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill_no_credit got rtn=%0d ovf=%b exp rtn=0 ovf=0", rtn_total - r0, stat_ovf);
    end
    send(1, 1, 6'd9, 0, 0);
    idle(1);
    checks++;
    if (stat_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b exp 1", stat_ovf);
    end
    bus.ppe_seg_ready = 1'b1;
    wait_drain();
    idle(3);
    checks++;
    if (rtn_total - r0 != 8 || bus.ppe_seg_valid !== 1'b0 || stat_pkt_cnt !== 32'd9) begin
      errors++;
      $display("FAIL ovf_drain got rtn=%0d valid=%b pkt=%0d exp rtn=8 valid=0 pkt=9", rtn_total - r0, bus.ppe_seg_valid, stat_pkt_cnt);
    end
  endtask
  task automatic test_drop_pop();
    bus.ppe_seg_ready = 1'b0;
    send(1, 1, 6'd3, 1, 0);
    idle(1);
    bus.ppe_seg_ready = 1'b1;
    send(0, 0, 6'd0, 0, 0);
    checks++;
    if (bus.tx_credit_rtn !== 2'd2 || stat_drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_pop got rtn=%0d drop=%0d exp rtn=2 drop=1", bus.tx_credit_rtn, stat_drop_cnt);
    end
    idle(1);
    wait_drain();
  endtask
  task automatic test_abort();
    bus.ppe_seg_ready = 1'b1;
    send(1, 0, 6'd0, 1, 0);
    send(0, 0, 6'd0, 1, 0);
    send(1, 1, 6'd7, 1, 1);
    idle(1);
    wait_drain();
    idle(2);
    checks++;
    if (stat_pkt_cnt !== 32'd11) begin
      errors++;
      $display("FAIL abort_pkt_cnt got %0d exp 11", stat_pkt_cnt);
    end
    send(0, 1, 6'd1, 0, 0);
    checks++;
    if (stat_drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL abort_fsm_idle got drop=%0d exp 2", stat_drop_cnt);
    end
    idle(2);
  endtask
  task automatic test_reset_mid();
    bus.ppe_seg_ready = 1'b0;
    send(1, 0, 6'd0, 1, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 6'd0, 1, 0);
    bus.egr_seg_valid = 1'b0;
    reset = 1'b1;
    step();
    sb.delete();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.ppe_seg_valid !== 1'b0 || bus.tx_credit_rtn !== 2'd0 || stat_pkt_cnt !== 0 || stat_drop_cnt !== 0 || stat_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b rtn=%0d pkt=%0d drop=%0d ovf=%b exp all 0",
               bus.ppe_seg_valid, bus.tx_credit_rtn, stat_pkt_cnt, stat_drop_cnt, stat_ovf);
    end
    bus.ppe_seg_ready = 1'b1;
    send(0, 0, 6'd0, 0, 0);
    idle(1);
    checks++;
    if (stat_drop_cnt !== 16'd1 || bus.ppe_seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fsm_idle got drop=%0d valid=%b exp drop=1 valid=0", stat_drop_cnt, bus.ppe_seg_valid);
    end
  endtask
  task automatic test_sat_clr();
    bus.egr_seg_valid = 1; bus.egr_seg_sop = 0; bus.egr_seg_eop = 0;
    for (int i = 0; i < 65534; i++) step();
    checks++;
    if (stat_drop_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_reach_max got %0h exp ffff", stat_drop_cnt);
    end
    step();
    checks++;
    if (stat_drop_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate got %0h exp ffff", stat_drop_cnt);
    end
    bus.ppe_seg_ready = 1'b0;
    send(1, 1, 6'd2, 1, 0);
    idle(1);
    bus.ppe_seg_ready = 1'b1;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++;
    if (stat_pkt_cnt !== 32'd0 || stat_drop_cnt !== 16'd0 || stat_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_pop got pkt=%0d drop=%0d ovf=%b exp 0 0 0", stat_pkt_cnt, stat_drop_cnt, stat_ovf);
    end
    wait_drain();
  endtask
  initial begin
    test_reset();
    test_pkt();
    test_overflow();
    test_drop_pop();
    test_abort();
    test_reset_mid();
    test_sat_clr();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
